// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared memory-interface constants and responder state encoding
package mem_if_pkg;

   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_DEPTH  = 512;
   localparam int LAT_MIN    = 1;
   localparam int LAT_MAX    = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   // Counter preload: the access edge is the one where the counter reads zero.
   function automatic logic [3:0] lat_load(input logic wr, input int rd_lat, input int wr_lat);
      return wr ? 4'(wr_lat - 1) : 4'(rd_lat - 1);
   endfunction

endpackage

// File: rtl/mem_array_sync.sv
// rtl/mem_array_sync.sv - single-port synchronous RAM with registered read
module mem_array_sync
   import mem_if_pkg::*;
#(
   parameter int DEPTH  = MEM_DEPTH,
   parameter int DATA_W = MEM_DATA_W,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      if (re) begin
         dout_q <= mem_q[addr];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - latency-programmable responder for the MAR/MDR memory port
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W,
   parameter int DEPTH  = MEM_DEPTH,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int          RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   generate
      if (RD_LAT < LAT_MIN || RD_LAT > LAT_MAX || WR_LAT < LAT_MIN || WR_LAT > LAT_MAX ||
          DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_param
         $error("mem_responder: illegal RD_LAT/WR_LAT/DEPTH parameter");
      end
   endgenerate

   mem_state_e        state_q;
   logic [3:0]        cnt_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic              busy_q;

   logic              in_range;
   logic              access_now;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_dout;

   assign in_range   = (32'(addr_q) < DEPTH_U);
   assign access_now = (state_q == ST_WAIT) && (cnt_q == 4'd0);

   // Reset wins over the access edge so an aborted write never reaches the array.
   assign ram_we = access_now && write_q && in_range && !rst;
   assign ram_re = access_now && !write_q && in_range && !rst;

   mem_array_sync #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (RAM_AW)
   ) u_array (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (addr_q[RAM_AW-1:0]),
      .din  (wdata_q),
      .dout (ram_dout)
   );

   // The array's output register is the read-data load; outside a read response the last value holds.
   always_comb begin
      rdata_d = rdata_q;
      if (state_q == ST_RESP && !write_q) begin
         rdata_d = resp_err_q ? '0 : ram_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rdata_q      <= rdata_d;
         resp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  write_q <= req_write;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  cnt_q   <= lat_load(req_write, RD_LAT, WR_LAT);
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= !in_range;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               resp_err_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == ST_IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_d;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder
module tb_mem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        req_valid;
   logic        req_write;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;

   logic        valid_a, valid_b;
   logic        ready_a, ready_b, rvalid_a, rvalid_b, rerr_a, rerr_b, busy_a, busy_b;
   logic [31:0] rdata_a, rdata_b;
   logic        ready, rvalid, rerr, busy;
   logic [31:0] rdata;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_rdata = 32'h0;
   exp_t        sb[$];

   always #5 clk = ~clk;

   assign valid_a = req_valid & ~sel;
   assign valid_b = req_valid & sel;
   assign ready   = sel ? ready_b  : ready_a;
   assign rvalid  = sel ? rvalid_b : rvalid_a;
   assign rerr    = sel ? rerr_b   : rerr_a;
   assign busy    = sel ? busy_b   : busy_a;
   assign rdata   = sel ? rdata_b  : rdata_a;

   mem_responder #(.DEPTH(256), .RD_LAT(2), .WR_LAT(1)) u_a (
      .clk(clk), .rst(rst), .req_valid(valid_a), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_a),
      .resp_valid(rvalid_a), .resp_rdata(rdata_a), .resp_err(rerr_a), .busy(busy_a)
   );

   mem_responder #(.DEPTH(512), .RD_LAT(2), .WR_LAT(4)) u_b (
      .clk(clk), .rst(rst), .req_valid(valid_b), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_b),
      .resp_valid(rvalid_b), .resp_rdata(rdata_b), .resp_err(rerr_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic w, input logic [31:0] rd_exp, input logic err_exp);
      exp_t e;
      e.err   = err_exp;
      e.rdata = w ? last_rdata : rd_exp;
      e.lat   = w ? (sel ? 4 : 1) : 2;
      if (!w) last_rdata = rd_exp;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag, input int lat);
      exp_t e;
      e = sb.pop_front();
      chk({tag, "_lat"},   32'(lat), 32'(e.lat));
      chk({tag, "_rdata"}, rdata,    e.rdata);
      chk({tag, "_err"},   32'(rerr), 32'(e.err));
   endtask

   task automatic wait_resp(input string tag);
      int n = 0;
      while (!rvalid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      pop_check(tag, n);
      @(posedge clk); #1;
      chk({tag, "_one_cycle"}, 32'(rvalid), 32'd0);
      chk({tag, "_idle"},      32'(busy),   32'd0);
   endtask

   task automatic do_req(input string tag, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input logic [31:0] rd_exp, input logic err_exp);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      push_exp(w, rd_exp, err_exp);
      @(posedge clk); #1;
      // Scramble the request bus while busy: only latched values may matter.
      req_valid = 1'b0;
      req_write = ~w;
      req_addr  = ~a;
      req_wdata = ~d;
      wait_resp(tag);
   endtask

   initial begin
      int seen;
      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0;

      @(posedge clk); #1;
      chk("rst_ready_c1", 32'(ready), 32'd0);
      @(posedge clk); #1;
      chk("rst_ready_c2", 32'(ready),  32'd0);
      chk("rst_rvalid",   32'(rvalid), 32'd0);
      chk("rst_rdata",    rdata,       32'd0);
      chk("rst_busy",     32'(busy),   32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(ready), 32'd1);

      do_req("wr_010", 1'b1, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0);
      do_req("rd_010", 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);

      do_req("wr_001", 1'b1, 9'h001, 32'h11, 32'h0, 1'b0);
      do_req("wr_002", 1'b1, 9'h002, 32'h22, 32'h0, 1'b0);

      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h001;
      push_exp(1'b0, 32'h11, 1'b0);
      @(posedge clk); #1;
      req_addr = 9'h002;
      @(posedge clk); #1;
      chk("b2b_ready_k1", 32'(ready), 32'd0);
      @(posedge clk); #1;
      chk("b2b_ready_k2", 32'(ready),  32'd0);
      chk("b2b_rvalid1",  32'(rvalid), 32'd1);
      pop_check("b2b_first", 2);
      @(posedge clk); #1;
      chk("b2b_ready_k3", 32'(ready), 32'd1);
      push_exp(1'b0, 32'h22, 1'b0);
      @(posedge clk); #1;
      chk("b2b_accept2_busy", 32'(busy), 32'd1);
      req_valid = 1'b0;
      wait_resp("b2b_second");

      do_req("wr_0f0",  1'b1, 9'h0F0, 32'h5A5A5A5A, 32'h0, 1'b0);
      do_req("wr_0ff",  1'b1, 9'h0FF, 32'h000000A5, 32'h0, 1'b0);
      do_req("wr_1f0",  1'b1, 9'h1F0, 32'h0000FFFF, 32'h0, 1'b1);
      do_req("wr_100",  1'b1, 9'h100, 32'h12345678, 32'h0, 1'b1);
      do_req("rd_1f0",  1'b0, 9'h1F0, 32'h0, 32'h0, 1'b1);
      do_req("rd_0f0",  1'b0, 9'h0F0, 32'h0, 32'h5A5A5A5A, 1'b0);
      do_req("rd_0ff",  1'b0, 9'h0FF, 32'h0, 32'h000000A5, 1'b0);
      do_req("rd_000",  1'b0, 9'h000, 32'h0, 32'h0, 1'b0);

      @(negedge clk);
      sel = 1'b1;
      last_rdata = 32'h0;
      do_req("b_wr_020", 1'b1, 9'h020, 32'h00001234, 32'h0, 1'b0);

      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h020; req_wdata = 32'h0000CAFE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b_mid_busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("b_mid_rst_ready",  32'(ready),  32'd0);
      chk("b_mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("b_mid_rst_busy",   32'(busy),   32'd0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      last_rdata = 32'h0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rvalid) seen++;
      end
      chk("b_mid_no_resp", 32'(seen), 32'd0);
      do_req("b_rd_020", 1'b0, 9'h020, 32'h0, 32'h00001234, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
